// File: rtl/arm_template_emitter.sv
`default_nettype none
// ============================================================================
// Module      : arm_template_emitter
// Description : Turns one bytecode selection into a stream of 32-bit ARM
//               instruction words. The selector is driven into the address
//               lookup, and the returned template slot is read word by word
//               from a synchronous template ROM. Each word is emitted on a
//               valid/ready stream.
// Ports       :
//   clk, rst            - clock, asynchronous active-high reset
//   req_valid/req_ready - bytecode request handshake, req_sel = {stage, op}
//   lut_sel / lut_adr   - selector out to lookup / slot index back
//   rom_en / rom_addr   - template ROM read strobe and {slot, idx} address
//   rom_data            - {last flag, ARM word}, one cycle after rom_en
//   out_valid/out_ready - ARM word stream handshake
//   out_data / out_last - ARM word and end-of-template marker
//   done / err          - one-cycle completion / unsupported-bytecode pulses
//   abort               - synchronous flush back to idle
// Revision    : 1.0 - initial release
// ============================================================================
module arm_template_emitter #(
    parameter int SLOT_W = 3,
    parameter int ADR_W  = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [8:0]              req_sel,
    output logic [8:0]              lut_sel,
    input  logic [ADR_W-1:0]        lut_adr,
    output logic                    rom_en,
    output logic [ADR_W+SLOT_W-1:0] rom_addr,
    input  logic [32:0]             rom_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_data,
    output logic                    out_last,
    output logic                    done,
    output logic                    err,
    input  logic                    abort
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_EMIT  = 2'd2;

    localparam logic [ADR_W-1:0]  c_ADR_EMPTY = '0;
    localparam logic [ADR_W-1:0]  c_ADR_NONE  = '1;
    localparam logic [SLOT_W-1:0] c_IDX_MAX   = '1;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [ADR_W-1:0]  r_slot;
    logic [SLOT_W-1:0] r_idx;
    logic [SLOT_W-1:0] w_idx_next;
    logic [31:0]       r_out_data;
    logic              r_out_last;
    logic              r_done;
    logic              r_err;

    logic w_accept;
    logic w_empty;
    logic w_unsup;
    logic w_start;
    logic w_hs;
    logic w_next_word;

    // abort outranks any request or handshake in the same cycle, so both
    // qualifiers are masked by it before they can start any side effect.
    assign w_accept    = (r_state == c_IDLE) && req_valid && !abort;
    assign w_empty     = (lut_adr == c_ADR_EMPTY);
    assign w_unsup     = (lut_adr == c_ADR_NONE);
    assign w_start     = w_accept && !w_empty && !w_unsup;
    assign w_hs        = (r_state == c_EMIT) && out_ready && !abort;
    assign w_next_word = w_hs && !r_out_last;
    assign w_idx_next  = r_idx + SLOT_W'(1);

    assign lut_sel   = req_sel;
    assign req_ready = (r_state == c_IDLE);
    assign out_valid = (r_state == c_EMIT);
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign done      = r_done;
    assign err       = r_err;

    // Next state and ROM read strobe. The ROM address is driven only while
    // the strobe is high so the bus idles at zero.
    always_comb begin
        w_state_next = r_state;
        rom_en       = 1'b0;
        rom_addr     = '0;
        case (r_state)
            c_IDLE: begin
                if (w_start) begin
                    w_state_next = c_FETCH;
                    rom_en       = 1'b1;
                    rom_addr     = {lut_adr, {SLOT_W{1'b0}}};
                end
            end
            c_FETCH: begin
                w_state_next = c_EMIT;
            end
            c_EMIT: begin
                if (w_hs) begin
                    if (r_out_last) begin
                        w_state_next = c_IDLE;
                    end else begin
                        w_state_next = c_FETCH;
                        rom_en       = 1'b1;
                        rom_addr     = {r_slot, w_idx_next};
                    end
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
        if (abort) begin
            w_state_next = c_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_slot     <= '0;
            r_idx      <= '0;
            r_out_data <= '0;
            r_out_last <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (w_accept && w_empty) || (w_hs && r_out_last);
            r_err   <= w_accept && w_unsup;

            if (w_start) begin
                r_slot <= lut_adr;
                r_idx  <= '0;
            end else if (w_next_word) begin
                r_idx <= w_idx_next;
            end

            // The final word of a slot always ends the template, so idx can
            // never step past the slot boundary.
            if ((r_state == c_FETCH) && !abort) begin
                r_out_data <= rom_data[31:0];
                r_out_last <= rom_data[32] || (r_idx == c_IDX_MAX);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arm_template_emitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_arm_template_emitter
// Description : Self-checking bench for arm_template_emitter. Holds a template
//               ROM, a selector lookup table and a queue-based model of the
//               expected word stream, plus directed scenarios with literal
//               expected values and cycle positions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arm_template_emitter;

    localparam int SLOT_W = 3;
    localparam int ADR_W  = 7;

    localparam logic [8:0] c_SEL_A     = 9'h060;  // slot 11, two words
    localparam logic [8:0] c_SEL_EMPTY = 9'h000;  // slot 0, empty template
    localparam logic [8:0] c_SEL_BAD   = 9'h0FE;  // lookup default 7F
    localparam logic [8:0] c_SEL_LONG  = 9'h115;  // slot 3, eight words

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        req_valid = 1'b0;
    logic [8:0]  req_sel   = '0;
    logic        out_ready = 1'b0;
    logic        abort     = 1'b0;

    logic        req_ready;
    logic [8:0]  lut_sel;
    logic [6:0]  lut_adr;
    logic        rom_en;
    logic [9:0]  rom_addr;
    logic [32:0] rom_data = '0;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        done;
    logic        err;

    logic [32:0] rom     [0:1023];
    logic [6:0]  lut_map [0:511];

    int n_pass   = 0;
    int n_total  = 0;
    int hs_count = 0;

    logic [32:0] exp_q[$];
    int          cur_slot    = 0;
    int          cur_k       = 0;
    bit          exp_done_n  = 1'b0;
    bit          exp_err_n   = 1'b0;

    arm_template_emitter #(
        .SLOT_W (SLOT_W),
        .ADR_W  (ADR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sel   (req_sel),
        .lut_sel   (lut_sel),
        .lut_adr   (lut_adr),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done),
        .err       (err),
        .abort     (abort)
    );

    always #5 clk = ~clk;

    assign lut_adr = lut_map[lut_sel];

    always @(posedge clk) begin
        if (rom_en) rom_data <= rom[rom_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: on acceptance, the whole expected word list of the template is
    // built from the ROM image; each handshake pops one word.
    task automatic model_step;
        bit          busy;
        bit          e_en;
        int          e_addr;
        bit          nd;
        bit          ne;
        logic [6:0]  a;
        logic [32:0] w;
        busy   = (exp_q.size() != 0);
        e_en   = 1'b0;
        e_addr = 0;
        nd     = 1'b0;
        ne     = 1'b0;
        chk("lut_sel", lut_sel, req_sel);
        chk("req_ready", req_ready, !busy);
        chk("done", done, exp_done_n);
        chk("err", err, exp_err_n);
        if (!busy) begin
            chk("out_valid_idle", out_valid, 0);
        end else if (out_valid) begin
            chk("out_data", out_data, exp_q[0][31:0]);
            chk("out_last", out_last, exp_q[0][32]);
        end
        if (abort) begin
            exp_q.delete();
        end else if (!busy && req_valid) begin
            a = lut_map[req_sel];
            if (a == 7'h00) nd = 1'b1;
            else if (a == 7'h7F) ne = 1'b1;
            else begin
                cur_slot = int'(a);
                cur_k    = 0;
                e_en     = 1'b1;
                e_addr   = cur_slot * 8;
                for (int k = 0; k < 8; k++) begin
                    w = rom[cur_slot * 8 + k];
                    if (k == 7) w[32] = 1'b1;
                    exp_q.push_back(w);
                    if (w[32]) break;
                end
            end
        end else if (busy && out_valid && out_ready) begin
            w = exp_q.pop_front();
            hs_count++;
            if (w[32]) nd = 1'b1;
            else begin
                cur_k++;
                e_en   = 1'b1;
                e_addr = cur_slot * 8 + cur_k;
            end
        end
        chk("rom_en", rom_en, e_en);
        chk("rom_addr", rom_addr, e_addr[9:0]);
        exp_done_n = nd;
        exp_err_n  = ne;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_done_n = 1'b0;
            exp_err_n  = 1'b0;
        end else begin
            model_step();
        end
    end

    // Counts negedges from the cycle after acceptance (that cycle is 1).
    task automatic wait_done(input int max, output int cyc);
        bit got;
        got = 1'b0;
        cyc = -1;
        for (int i = 1; i <= max && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                cyc = i;
            end
        end
        chk("done_seen", got, 1);
    endtask

    task automatic issue(input logic [8:0] sel);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_sel   = sel;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int hs0;
        for (int i = 0; i < 1024; i++) rom[i] = {1'b1, 32'hDEAD0000 | i};
        for (int i = 0; i < 512; i++) lut_map[i] = 7'h7F;
        lut_map[c_SEL_A]     = 7'd11;
        lut_map[c_SEL_EMPTY] = 7'd0;
        lut_map[c_SEL_LONG]  = 7'd3;
        rom[88] = {1'b0, 32'hE3A00001};
        rom[89] = {1'b1, 32'hE12FFF1E};
        for (int k = 0; k < 8; k++) rom[24 + k] = {1'b0, 32'hE2800000 | k};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rom_en", rom_en, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;

        // Two-word template, out_ready high
        out_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_sel   = c_SEL_A;
        @(negedge clk);
        chk("s1_c0_rom_en", rom_en, 1);
        chk("s1_c0_rom_addr", rom_addr, 88);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("s1_c1_valid", out_valid, 0);
        chk("s1_c1_ready", req_ready, 0);
        @(negedge clk);
        chk("s1_c2_valid", out_valid, 1);
        chk("s1_c2_data", out_data, 32'hE3A00001);
        chk("s1_c2_last", out_last, 0);
        chk("s1_c2_rom_addr", rom_addr, 89);
        @(negedge clk);
        chk("s1_c3_valid", out_valid, 0);
        @(negedge clk);
        chk("s1_c4_valid", out_valid, 1);
        chk("s1_c4_data", out_data, 32'hE12FFF1E);
        chk("s1_c4_last", out_last, 1);
        @(negedge clk);
        chk("s1_c5_done", done, 1);
        chk("s1_c5_ready", req_ready, 1);

        // Empty and unsupported templates
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_sel   = c_SEL_EMPTY;
        @(negedge clk);
        chk("s2_empty_rom_en", rom_en, 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("s2_empty_done", done, 1);
        chk("s2_empty_err", err, 0);
        chk("s2_empty_valid", out_valid, 0);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_sel   = c_SEL_BAD;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("s2_bad_err", err, 1);
        chk("s2_bad_done", done, 0);

        // Back-to-back empty / unsupported / empty
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_sel   = c_SEL_EMPTY;
        @(posedge clk); #1;
        req_sel   = c_SEL_BAD;
        @(negedge clk);
        chk("s2_b2b_done0", done, 1);
        @(posedge clk); #1;
        req_sel   = c_SEL_EMPTY;
        @(negedge clk);
        chk("s2_b2b_err1", err, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("s2_b2b_done2", done, 1);

        // Backpressure on word 0
        out_ready = 1'b0;
        issue(c_SEL_A);
        @(negedge clk);
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            chk("s3_hold_valid", out_valid, 1);
            chk("s3_hold_data", out_data, 32'hE3A00001);
            chk("s3_hold_last", out_last, 0);
            chk("s3_hold_rom_en", rom_en, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("s3_hs_rom_en", rom_en, 1);
        chk("s3_hs_rom_addr", rom_addr, 89);
        wait_done(20, cyc);

        // Full eight-word slot without ROM last flag
        hs0 = hs_count;
        issue(c_SEL_LONG);
        wait_done(40, cyc);
        chk("s4_done_cycle", cyc, 17);
        chk("s4_words", hs_count - hs0, 8);

        // abort in EMIT of word 1, concurrent with a handshake
        issue(c_SEL_A);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        abort = 1'b1;
        @(negedge clk);
        chk("s5_abort_rom_en", rom_en, 0);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("s5_after_valid", out_valid, 0);
        chk("s5_after_done", done, 0);
        chk("s5_after_ready", req_ready, 1);
        hs0 = hs_count;
        issue(c_SEL_A);
        wait_done(20, cyc);
        chk("s5_redo_cycle", cyc, 5);
        chk("s5_redo_words", hs_count - hs0, 2);

        // Reset pulsed during FETCH
        issue(c_SEL_A);
        #1;
        rst = 1'b1;
        #1;
        chk("s6_req_ready", req_ready, 1);
        chk("s6_out_valid", out_valid, 0);
        chk("s6_rom_en", rom_en, 0);
        chk("s6_rom_addr", rom_addr, 0);
        chk("s6_out_data", out_data, 0);
        chk("s6_out_last", out_last, 0);
        chk("s6_done", done, 0);
        chk("s6_err", err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        hs0 = hs_count;
        issue(c_SEL_A);
        wait_done(20, cyc);
        chk("s6_redo_cycle", cyc, 5);
        chk("s6_redo_words", hs_count - hs0, 2);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arm_template_emitter.md
# arm_template_emitter

Sequencer that turns one JVM bytecode selection into a stream of 32-bit ARM instruction words. It drives a 9-bit selector into the instruction-address lookup and captures the returned 7-bit template slot. It then reads that slot from the synchronous template ROM word by word and emits each word over a valid/ready stream to the code-buffer writer. It sits between the bytecode decoder (request side) and the JIT code buffer (output side).

## Interface
- SLOT_W, 3: log2 of words per template slot (8 words per slot).
- ADR_W, 7: template slot index width (lookup output width).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  bytecode request valid.
- req_ready  out  1  block can accept a request.
- req_sel  in  9  {stage bit, 8-bit opcode}.
- lut_sel  out  9  selector to the address lookup; equals req_sel, combinational.
- lut_adr  in  ADR_W  slot index returned combinationally by the lookup.
- rom_en  out  1  template ROM read strobe.
- rom_addr  out  ADR_W+SLOT_W  ROM word address = {slot, idx}.
- rom_data  in  33  {last flag, ARM word}; valid 1 cycle after rom_en.
- out_valid  out  1  ARM word valid.
- out_ready  in  1  downstream accepts word.
- out_data  out  32  ARM instruction word.
- out_last  out  1  final word of this template.
- done  out  1  one-cycle pulse: request fully emitted (including empty template).
- err  out  1  one-cycle pulse: unsupported bytecode (lut_adr = all ones).
- abort  in  1  synchronous flush to IDLE.

## Operation
- States: IDLE, FETCH, EMIT.
- IDLE: req_ready=1. On req_valid:
  - lut_adr=0 (empty template): no ROM read; done=1 next cycle; stay IDLE.
  - lut_adr=7'h7F (lookup default): err=1 next cycle; stay IDLE.
  - Otherwise: latch slot=lut_adr, idx=0; rom_en=1 with rom_addr={lut_adr,0} in the same cycle; go to FETCH.
- FETCH: register rom_data[31:0] into out_data. Register out_last = rom_data[32] | (idx == 2^SLOT_W-1). Go to EMIT.
- EMIT: out_valid=1. out_data and out_last are held stable until out_ready.
  - Handshake with out_last=1: done=1 next cycle; go to IDLE.
  - Handshake with out_last=0: idx+1; rom_en=1, rom_addr={slot,idx+1} in the same cycle; go to FETCH.
- idx never wraps. Word 2^SLOT_W-1 always terminates the template, even if its ROM last flag is clear.
- abort: in any state, next state is IDLE. Clears out_valid. No done or err is produced. An in-flight ROM read is discarded. abort takes priority over a same-cycle handshake or request.
- req_ready=0 outside IDLE. Requests arriving then are not sampled.
- done and err are never asserted together.

## Timing
- Reset values: req_ready=1 (state IDLE), rom_en=0, rom_addr=0, out_valid=0, out_data=0, out_last=0, done=0, err=0, idx=0, slot=0.
- Reset asserted mid-template returns the block to IDLE asynchronously and drops out_valid immediately.
- Accept at cycle 0, FETCH at cycle 1, first out_valid at cycle 2.
- With out_ready held high, each word takes 2 cycles: N words complete in 2N cycles. done rises at cycle 2N+1.
- Empty or unsupported template: done or err at cycle 1. req_ready stays 1, so back-to-back requests are accepted every cycle.
- After the last handshake, req_ready=1 on the next cycle, the same cycle done pulses.

## Test plan
- lut_adr=11; ROM[88]={0,0xE3A00001}, ROM[89]={1,0xE12FFF1E}; out_ready=1 -> words 0xE3A00001 (last=0) then 0xE12FFF1E (last=1) at cycles 2 and 4; done=1 at cycle 5; rom_addr 88, 89.
- lut_adr=0 -> no rom_en, no out_valid, done=1 at cycle 1. lut_adr=7'h7F -> err=1 at cycle 1, done=0.
- Backpressure: out_ready=0 for 5 cycles during word 0 -> out_valid, out_data and out_last held constant; no new rom_en until the handshake.
- Slot 3 has all 8 words with last flag clear -> 8 words emitted from rom_addr 24..31; out_last=1 on the 8th; then done.
- abort in EMIT of word 1 -> next cycle IDLE, out_valid=0, no done. A following request with lut_adr=11 emits correctly from word 0.
- rst pulsed during FETCH -> all outputs at reset values immediately. After release, a fresh request behaves as in the first scenario.
